serial_subtractor_ctrl: RTL and testbench

//   Bit-serial WIDTH-bit subtract engine: sequences one full_subtractor cell LSB-first over

---
 rtl/sub_ctrl_pkg.sv | 12 +
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor_ctrl.sv | 107 ++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtract engine.
//   state_t : controller state encoding. The fourth code, 2'd3, is never
//             entered. If it ever appears, the next state is S_IDLE.
package sub_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: computes a - b - cin.
//   a, b, cin : minuend bit, subtrahend bit, borrow-in
//   dif       : difference bit
//   brw       : borrow-out (1 when a < b + cin)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic dif,
  output logic brw
);

  assign dif = a ^ b ^ cin;
  assign brw = (~a & b) | (~(a ^ b) & cin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor. It computes diff = a - b - bin (mod 2^WIDTH)
// and the final borrow. It walks one full_subtractor cell over the operands,
// LSB first, for WIDTH cycles. The borrow is carried from bit to bit in a
// register.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only while idle)
//   a_in, b_in, bin      : minuend, subtrahend, borrow-in for bit 0
//   out_valid / out_ready: result handshake (valid only while done)
//   diff_out, borrow_out : registered result. It is held after the handshake.
module serial_subtractor_ctrl
  import sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, diff_sh;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             dif, brw;
  logic             last_bit;
  logic [WIDTH-1:0] diff_nxt;
  logic             accept, step;

  full_subtractor u_fs (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (br),
    .dif (dif),
    .brw (brw)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  // Each new difference bit enters at the MSB. After WIDTH shifts, bit 0 has
  // reached bit 0.
  assign diff_nxt = {dif, diff_sh[WIDTH-1:1]};

  // NOTE: state elements use non-blocking assignments, so every register
  // samples the pre-edge values and the update order does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default first, so every path assigns state_nxt and no latch is
  // inferred.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = in_valid ? S_RUN : S_IDLE;
      S_RUN:   state_nxt = last_bit ? S_DONE : S_RUN;
      S_DONE:  state_nxt = out_ready ? S_IDLE : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    accept    = (state == S_IDLE) && in_valid;
    step      = (state == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      diff_sh    <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      a_sh <= a_in;
      b_sh <= b_in;
      br   <= bin;
      cnt  <= '0;
    end else if (step) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      br      <= brw;
      diff_sh <= diff_nxt;
      if (last_bit) begin
        // The counter stops at WIDTH-1. It is reloaded on the next acceptance.
        diff_out   <= diff_nxt;
        borrow_out <= brw;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       iv8, ir8, ov8, ordy8, bin8, bo8;
  logic [7:0] a8, b8, d8;
  // WIDTH=3 instance
  logic       iv3, ir3, ov3, ordy3, bin3, bo3;
  logic [2:0] a3, b3, d3;

  serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a_in(a8), .b_in(b8), .bin(bin8), .out_valid(ov8), .out_ready(ordy8),
    .diff_out(d8), .borrow_out(bo8)
  );

  serial_subtractor_ctrl #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3),
    .a_in(a3), .b_in(b3), .bin(bin3), .out_valid(ov3), .out_ready(ordy3),
    .diff_out(d3), .borrow_out(bo3)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference model, index 0 = WIDTH 8, index 1 = WIDTH 3.
  // It tracks: busy from acceptance to output handshake, result visible
  // WIDTH edges after acceptance, and the result value computed arithmetically.
  int          wid[2] = '{8, 3};
  logic [31:0] m_a[2], m_b[2];
  logic        m_iv[2], m_bin[2], m_ordy[2];
  assign m_a[0] = 32'(a8);  assign m_b[0] = 32'(b8);
  assign m_a[1] = 32'(a3);  assign m_b[1] = 32'(b3);
  assign m_iv[0] = iv8;     assign m_bin[0] = bin8;  assign m_ordy[0] = ordy8;
  assign m_iv[1] = iv3;     assign m_bin[1] = bin3;  assign m_ordy[1] = ordy3;

  bit          busy[2], outv[2], mbor[2], pendb[2];
  logic [31:0] mdiff[2], pend[2];
  int          acc[2];
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [32:0] ref_sub(input logic [31:0] a, input logic [31:0] b,
                                          input logic bi, input int w);
    longint d, mask;
    d    = longint'(a) - longint'(b) - longint'(bi);
    mask = (longint'(1) << w) - 1;
    return {d < 0, 32'(d & mask)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        busy[i] <= 0; outv[i] <= 0; mdiff[i] <= '0; mbor[i] <= 0;
      end else if (outv[i]) begin
        if (m_ordy[i]) begin outv[i] <= 0; busy[i] <= 0; end
      end else if (busy[i]) begin
        if (cyc - acc[i] == wid[i]) begin
          outv[i] <= 1; mdiff[i] <= pend[i]; mbor[i] <= pendb[i];
        end
      end else if (m_iv[i]) begin
        logic [32:0] r;
        r = ref_sub(m_a[i], m_b[i], m_bin[i], wid[i]);
        busy[i] <= 1; acc[i] <= cyc; pend[i] <= r[31:0]; pendb[i] <= r[32];
      end
    end
  end

  // Per-cycle comparison against the model, on the inactive edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready8",  32'(ir8), 32'(!busy[0]));
      check("out_valid8", 32'(ov8), 32'(outv[0]));
      check("diff8",      32'(d8),  mdiff[0]);
      check("borrow8",    32'(bo8), 32'(mbor[0]));
      check("in_ready3",  32'(ir3), 32'(!busy[1]));
      check("out_valid3", 32'(ov3), 32'(outv[1]));
      check("diff3",      32'(d3),  mdiff[1]);
      check("borrow3",    32'(bo3), 32'(mbor[1]));
    end
  end

  int hs3 = 0;
  always @(posedge clk) if (rst_n && ov3 && ordy3) hs3 <= hs3 + 1;

  // Issue one WIDTH=8 operation and check latency and result against literals.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input logic [7:0] ed, input logic eb, input bit hs);
    int n;
    n = 0;
    a8 = a; b8 = b; bin8 = bi; iv8 = 1'b1;
    while (!ir8 && n < 50) begin @(posedge clk); #2; n++; end
    check("accept_timeout8", 32'(n < 50), 32'd1);
    @(posedge clk); #2;               // acceptance edge
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 50) begin @(posedge clk); #2; n++; end
    check("latency8", 32'(n), 32'd8);
    check("lit_diff8", 32'(d8), 32'(ed));
    check("lit_borrow8", 32'(bo8), 32'(eb));
    if (hs) begin
      ordy8 = 1'b1; @(posedge clk); #2; ordy8 = 1'b0;
      check("idle_after_hs8", 32'(ir8), 32'd1);
      check("ov_after_hs8", 32'(ov8), 32'd0);
    end
  endtask

  initial begin
    int n, idx;
    bit rb;
    rst_n = 1'b0;
    iv8 = 0; ordy8 = 0; a8 = '0; b8 = '0; bin8 = 0;
    iv3 = 0; ordy3 = 0; a3 = '0; b3 = '0; bin3 = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("reset_in_ready8", 32'(ir8), 32'd1);
    check("reset_out_valid8", 32'(ov8), 32'd0);
    check("reset_diff8", 32'(d8), 32'd0);
    check("reset_borrow8", 32'(bo8), 32'd0);
    @(posedge clk); #2;

    // Directed WIDTH=8 cases
    op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1);
    op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1);
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1);
    op8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1);
    op8(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1);

    // Backpressure: result held for 5 cycles, and a pulsed in_valid is ignored.
    op8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 0);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin iv8 = 1'b1; a8 = 8'hAA; b8 = 8'h01; bin8 = 1'b1; end
      else iv8 = 1'b0;
      @(posedge clk); #2;
      check("bp_out_valid8", 32'(ov8), 32'd1);
      check("bp_diff8", 32'(d8), 32'h22);
      check("bp_borrow8", 32'(bo8), 32'd0);
      check("bp_in_ready8", 32'(ir8), 32'd0);
    end
    iv8 = 1'b0;
    ordy8 = 1'b1; @(posedge clk); #2; ordy8 = 1'b0;
    check("bp_release_in_ready8", 32'(ir8), 32'd1);
    check("bp_release_out_valid8", 32'(ov8), 32'd0);
    check("bp_hold_diff8", 32'(d8), 32'h22);

    // Reset in the middle of RUN, after 4 bits have been processed.
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #2;               // acceptance edge
    iv8 = 1'b0;
    repeat (4) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    #1;
    check("abort_out_valid8", 32'(ov8), 32'd0);
    check("abort_diff8", 32'(d8), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    #1;
    check("abort_in_ready8", 32'(ir8), 32'd1);
    check("abort_no_result8", 32'(ov8), 32'd0);
    @(posedge clk); #2;
    op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1);

    // WIDTH=3: all 128 operand combinations, back-to-back in_valid, random stalls
    idx = 0; n = 0;
    {a3, b3, bin3} = 7'(idx);
    iv3 = 1'b1;
    while (idx < 128 && n < 20000) begin
      rb = ir3;
      @(posedge clk); #2; n++;
      ordy3 = 1'($urandom_range(0, 1));
      if (rb) begin
        idx++;
        if (idx < 128) {a3, b3, bin3} = 7'(idx);
        else iv3 = 1'b0;
      end
    end
    check("exh_feed_timeout3", 32'(idx), 32'd128);
    ordy3 = 1'b1;
    n = 0;
    while ((ov3 || !ir3) && n < 100) begin @(posedge clk); #2; n++; end
    ordy3 = 1'b0;
    check("exh_drain_timeout3", 32'(n < 100), 32'd1);
    check("exh_result_count3", 32'(hs3), 32'd128);

    @(posedge clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
